imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_pkg.sv | 19 +
 rtl/boot_word_assembler.sv | 36 +++
 rtl/imem_boot_loader.sv | 184 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Optional checksum stage is enabled by IMEM_BOOT_CHECKSUM_EN.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    ST_HDR0    = 3'd0,
    ST_HDR1    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_WRITE   = 3'd3,
    ST_CSUM    = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } boot_state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/boot_word_assembler.sv
// Shifts incoming bytes into a little-endian word; flags the byte that completes it.
module boot_word_assembler
  import imem_boot_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_shift_en,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_ready_c
);

  logic [DATA_W-1:0]     r_word;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_shift_en) begin
      r_word     <= {i_byte, r_word[DATA_W-1:8]};
      r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
    end
  end

  assign o_word         = r_word;
  assign o_word_ready_c = i_shift_en && (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the core in reset until done.
// Define IMEM_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst_n,
  output logic              boot_done,
  output logic              boot_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned LEN_W = 8 * HDR_BYTES;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  boot_state_e       r_state;
  boot_state_e       w_next_state;
  logic              r_rx_ready;
  logic              r_imem_we;
  logic              r_cpu_rst_n;
  logic              r_boot_done;
  logic              r_boot_err;
  logic [ADDR_W:0]   r_words_loaded;
  logic [LEN_W-1:0]  r_len;
  logic [TMO_W-1:0]  r_tmo;
  logic              w_accept;
  logic              w_word_ready;
  logic [DATA_W-1:0] w_word;
  logic [LEN_W-1:0]  w_len_full;
  logic              w_timeout;
  logic              w_last_word;
  logic              w_restart_ok;
  logic              w_asm_clear;
  logic              w_shift_en;

  assign w_accept     = rx_valid && r_rx_ready;
  assign w_len_full   = {rx_data, r_len[LEN_W-1:8]};
  assign w_timeout    = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign w_last_word  = (LEN_W'(r_words_loaded) + LEN_W'(1)) == r_len;
  assign w_restart_ok = restart && ((r_state == ST_DONE) || (r_state == ST_ERROR));
  assign w_asm_clear  = (r_state == ST_HDR0) || (r_state == ST_HDR1);
  assign w_shift_en   = w_accept && (r_state == ST_PAYLOAD);

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum <= '0;
    end else if (r_state == ST_HDR0) begin
      r_csum <= '0;
    end else if (w_shift_en) begin
      r_csum <= r_csum ^ rx_data;
    end
  end
`endif

  boot_word_assembler #(
    .DATA_W(DATA_W)
  ) u_asm (
    .clk            (clk),
    .rst_n          (rst),
    .i_clear        (w_asm_clear),
    .i_shift_en     (w_shift_en),
    .i_byte         (rx_data),
    .o_word         (w_word),
    .o_word_ready_c (w_word_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_HDR0;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_HDR0: begin
        if (w_accept) w_next_state = ST_HDR1;
      end
      ST_HDR1: begin
        if (w_accept) begin
          if ((w_len_full == '0) || (32'(w_len_full) > DEPTH)) w_next_state = ST_ERROR;
          else                                                 w_next_state = ST_PAYLOAD;
        end else if (w_timeout) begin
          w_next_state = ST_ERROR;
        end
      end
      ST_PAYLOAD: begin
        if (w_accept) begin
          if (w_word_ready) w_next_state = ST_WRITE;
        end else if (w_timeout) begin
          w_next_state = ST_ERROR;
        end
      end
      ST_WRITE: begin
        if (w_last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          w_next_state = ST_CSUM;
`else
          w_next_state = ST_DONE;
`endif
        end else begin
          w_next_state = ST_PAYLOAD;
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CSUM: begin
        if (w_accept) begin
          if (rx_data == r_csum) w_next_state = ST_DONE;
          else                   w_next_state = ST_ERROR;
        end else if (w_timeout) begin
          w_next_state = ST_ERROR;
        end
      end
`endif
      ST_DONE, ST_ERROR: begin
        if (restart) w_next_state = ST_HDR0;
      end
      default: w_next_state = ST_HDR0;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_ready  <= 1'b0;
      r_imem_we   <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_boot_done <= 1'b0;
      r_boot_err  <= 1'b0;
    end else begin
      r_rx_ready  <= (w_next_state == ST_HDR0) || (w_next_state == ST_HDR1) ||
                     (w_next_state == ST_PAYLOAD) || (w_next_state == ST_CSUM);
      r_imem_we   <= (w_next_state == ST_WRITE);
      r_cpu_rst_n <= (w_next_state == ST_DONE);
      r_boot_done <= (w_next_state == ST_DONE);
      r_boot_err  <= (w_next_state == ST_ERROR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len          <= '0;
      r_words_loaded <= '0;
      r_tmo          <= '0;
    end else begin
      if (w_accept && ((r_state == ST_HDR0) || (r_state == ST_HDR1)))
        r_len <= w_len_full;
      if (w_restart_ok)
        r_words_loaded <= '0;
      else if (r_state == ST_WRITE)
        r_words_loaded <= r_words_loaded + (ADDR_W + 1)'(1);
      // Idle counter restarts on every byte and state change, and saturates.
      if (w_accept || (w_next_state != r_state))
        r_tmo <= '0;
      else if (!w_timeout)
        r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign rx_ready     = r_rx_ready;
  assign imem_we      = r_imem_we;
  assign imem_waddr   = r_words_loaded[ADDR_W-1:0];
  assign imem_wdata   = w_word;
  assign cpu_rst_n    = r_cpu_rst_n;
  assign boot_done    = r_boot_done;
  assign boot_err     = r_boot_err;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes queued at stimulus, checked on imem_we.
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TMO_CYC = 16;

  logic              clk;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_rst_n;
  logic              boot_done;
  logic              boot_err;
  logic [ADDR_W:0]   words_loaded;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_wr_t;

  exp_wr_t     exp_q[$];
  logic [31:0] frame_words[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  imem_boot_loader #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .restart      (restart),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .boot_done    (boot_done),
    .boot_err     (boot_err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Memory-write monitor: every pulse must match the head of the scoreboard.
  initial begin
    exp_wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", 64'(imem_waddr), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("we_addr", 64'(imem_waddr), 64'(e.addr));
          check("we_data", 64'(imem_wdata), 64'(e.data));
        end
        check("rx_ready_in_write", 64'(rx_ready), 64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is consumed.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("rx_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends header plus frame_words; queues expected writes (and checksum when enabled).
  task automatic send_frame(input logic [15:0] len, input bit gaps);
    logic [7:0]  x;
    logic [31:0] w;
    x = 8'h00;
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    for (int i = 0; i < frame_words.size(); i++) begin
      exp_wr_t e;
      w = frame_words[i];
      e.addr = ADDR_W'(i);
      e.data = w;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        x = x ^ w[k*8 +: 8];
        send_byte(w[k*8 +: 8], gaps);
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(x, gaps);
`endif
  endtask

  task automatic wait_end(input int max_cyc, output int n);
    n = 0;
    while (!(boot_done || boot_err) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) check("wait_end_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("rst_done", 64'(boot_done), 64'd0);
    check("rst_err", 64'(boot_err), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
  endtask

  task automatic check_done(input string tag, input int words);
    check({tag, "_done"}, 64'(boot_done), 64'd1);
    check({tag, "_err"}, 64'(boot_err), 64'd0);
    check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd1);
    check({tag, "_words"}, 64'(words_loaded), 64'(words));
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_err(input string tag, input int words);
    check({tag, "_err"}, 64'(boot_err), 64'd1);
    check({tag, "_done"}, 64'(boot_done), 64'd0);
    check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'(words));
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    restart  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_ready", 64'(rx_ready), 64'd0);
    check("reset_we", 64'(imem_we), 64'd0);
    check("reset_waddr", 64'(imem_waddr), 64'd0);
    check("reset_wdata", 64'(imem_wdata), 64'd0);
    check("reset_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("reset_done", 64'(boot_done), 64'd0);
    check("reset_err", 64'(boot_err), 64'd0);
    check("reset_words", 64'(words_loaded), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rx_ready_after_reset", 64'(rx_ready), 64'd1);

    // Two-word frame, source always valid
    frame_words = '{32'h0000_0013, 32'h0010_0093};
    send_frame(16'd2, 1'b0);
    wait_end(50, n);
`ifdef IMEM_BOOT_CHECKSUM_EN
    check("done_latency", 64'(n), 64'd0);
`else
    check("done_latency", 64'(n), 64'd1);
`endif
    check_done("two_words", 2);
    do_restart();

    // Zero-length header
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end(20, n);
    check_err("len0", 0);
    do_restart();

    // Oversized header (65 words)
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end(20, n);
    check_err("len65", 0);
    do_restart();

    // Full-depth image
    frame_words.delete();
    for (int i = 0; i < 64; i++) frame_words.push_back($urandom);
    send_frame(16'd64, 1'b0);
    wait_end(50, n);
    check_done("len64", 64);
    do_restart();

    // Stall inside a word until timeout
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    wait_end(3 * TMO_CYC, n);
    check_err("timeout", 0);
    do_restart();

    // Randomly gapped 3-word frame with an ignored restart pulse in the payload
    frame_words = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_0F0F};
    begin
      exp_wr_t e;
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
        e.addr = ADDR_W'(i);
        e.data = frame_words[i];
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
          send_byte(frame_words[i][k*8 +: 8], 1'b1);
          if (i == 1 && k == 1) begin
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
            check("restart_ignored_rx_ready", 64'(rx_ready), 64'd1);
            check("restart_ignored_words", 64'(words_loaded), 64'd1);
          end
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^
                8'hA5 ^ 8'hA5 ^ 8'h0F ^ 8'h0F, 1'b1);
`endif
    end
    wait_end(50, n);
    check_done("gapped", 3);
    do_restart();

    // Reset after first word of three, then a clean reload
    exp_q.push_back('{addr: ADDR_W'(0), data: 32'h0000_00C1});
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hC1, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_words_before_rst", 64'(words_loaded), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_words", 64'(words_loaded), 64'd0);
    check("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
    check("mid_rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    frame_words = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
    send_frame(16'd3, 1'b0);
    wait_end(50, n);
    check_done("reload", 3);

`ifdef IMEM_BOOT_CHECKSUM_EN
    do_restart();
    frame_words = '{32'h4433_2211};
    send_frame(16'd1, 1'b0);
    wait_end(50, n);
    check_done("csum_good", 1);
    do_restart();
    exp_q.push_back('{addr: ADDR_W'(0), data: 32'h4433_2211});
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h45, 1'b0);
    wait_end(50, n);
    check_err("csum_bad", 1);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
